// File: rtl/pixel_write_ctrl.sv
// Ping-pong pixel frame writer: streams one frame of pixels into the write bank,
// then swaps banks once the downstream reader has released the other one.
module pixel_write_ctrl #(
    parameter int FRAME_PIXELS = 1024,
    parameter int ADDR_W       = 10
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              frame_start,
    input  logic [7:0]        pixel_in,
    input  logic              pixel_valid,
    output logic              pixel_ready,
    input  logic              consumer_done,
    output logic [ADDR_W-1:0] address_a,
    output logic [7:0]        data_a,
    output logic              wren_a,
    output logic              select,
    output logic              frame_done,
    output logic              overrun_err
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITE     = 2'd1,
        WAIT_BANK = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(FRAME_PIXELS - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic              wren_q, wren_d;
    logic              sel_q, sel_d;
    logic              done_q, done_d;
    logic              ovr_q, ovr_d;
    logic              free_q, free_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wren_d  = 1'b0;
        done_d  = 1'b0;
        sel_d   = sel_q;
        ovr_d   = ovr_q;
        free_d  = free_q | consumer_done;

        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    cnt_d   = '0;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (frame_start) ovr_d = 1'b1;
                // pixel_ready is high throughout WRITE, so valid alone means accept
                if (pixel_valid) begin
                    wren_d = 1'b1;
                    addr_d = cnt_q;
                    data_d = pixel_in;
                    if (cnt_q == LAST_PIX) begin
                        done_d = 1'b1;
                        if (free_q || consumer_done) begin
                            sel_d   = ~sel_q;
                            free_d  = 1'b0;
                            state_d = IDLE;
                        end else begin
                            state_d = WAIT_BANK;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            WAIT_BANK: begin
                if (frame_start) ovr_d = 1'b1;
                if (consumer_done) begin
                    sel_d   = ~sel_q;
                    free_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            wren_q  <= 1'b0;
            sel_q   <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
            free_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wren_q  <= wren_d;
            sel_q   <= sel_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
            free_q  <= free_d;
        end
    end

    assign pixel_ready = (state_q == WRITE);
    assign address_a   = addr_q;
    assign data_a      = data_q;
    assign wren_a      = wren_q;
    assign select      = sel_q;
    assign frame_done  = done_q;
    assign overrun_err = ovr_q;

endmodule

// File: tb/tb_pixel_write_ctrl.sv
// Directed bench for pixel_write_ctrl with a 4-pixel frame: table of per-cycle
// inputs and expected post-edge outputs, plus a hand-written mid-frame reset sequence.
module tb_pixel_write_ctrl;

    localparam int FP = 4;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          n_rst;
    logic          frame_start;
    logic [7:0]    pixel_in;
    logic          pixel_valid;
    logic          pixel_ready;
    logic          consumer_done;
    logic [AW-1:0] address_a;
    logic [7:0]    data_a;
    logic          wren_a;
    logic          select;
    logic          frame_done;
    logic          overrun_err;

    int total  = 0;
    int passed = 0;

    pixel_write_ctrl #(.FRAME_PIXELS(FP), .ADDR_W(AW)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .frame_start   (frame_start),
        .pixel_in      (pixel_in),
        .pixel_valid   (pixel_valid),
        .pixel_ready   (pixel_ready),
        .consumer_done (consumer_done),
        .address_a     (address_a),
        .data_a        (data_a),
        .wren_a        (wren_a),
        .select        (select),
        .frame_done    (frame_done),
        .overrun_err   (overrun_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          fs;
        logic          pv;
        logic [7:0]    px;
        logic          cd;
        logic          rdy;
        logic          wr;
        logic [AW-1:0] a;
        logic [7:0]    d;
        logic          s;
        logic          dn;
        logic          o;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic fs, input logic pv, input logic [7:0] px,
                                input logic cd, input logic rdy, input logic wr,
                                input logic [AW-1:0] a, input logic [7:0] d,
                                input logic s, input logic dn, input logic o);
        vec_t v;
        v.fs = fs; v.pv = pv; v.px = px; v.cd = cd;
        v.rdy = rdy; v.wr = wr; v.a = a; v.d = d; v.s = s; v.dn = dn; v.o = o;
        return v;
    endfunction

    // Output word layout: {ready, wren, addr, data, select, frame_done, overrun}
    task automatic check(input string nm, input logic [AW+12:0] exp_w);
        logic [AW+12:0] act;
        act = {pixel_ready, wren_a, address_a, data_a, select, frame_done, overrun_err};
        total++;
        if (act === exp_w) passed++;
        else $display("FAIL %s: got rdy=%b wr=%b a=%0d d=%h s=%b dn=%b o=%b, expected rdy=%b wr=%b a=%0d d=%h s=%b dn=%b o=%b",
                      nm, act[AW+12], act[AW+11], act[AW+10:11], act[10:3], act[2], act[1], act[0],
                      exp_w[AW+12], exp_w[AW+11], exp_w[AW+10:11], exp_w[10:3], exp_w[2], exp_w[1], exp_w[0]);
    endtask

    task automatic step(input vec_t v, input string nm);
        frame_start   = v.fs;
        pixel_valid   = v.pv;
        pixel_in      = v.px;
        consumer_done = v.cd;
        @(posedge clk);
        #1;
        check(nm, {v.rdy, v.wr, v.a, v.d, v.s, v.dn, v.o});
    endtask

    initial begin
        n_rst = 1'b0;
        frame_start = 1'b0; pixel_valid = 1'b0; pixel_in = 8'h00; consumer_done = 1'b0;

        //                fs  pv  px     cd   rdy wr  a  d      s  dn o
        // Frame 1: continuous stream, bank free -> select 0->1
        tbl.push_back(mk(1, 0, 8'h00, 0,   1, 0, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h10, 0,   1, 1, 0, 8'h10, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h11, 0,   1, 1, 1, 8'h11, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h12, 0,   1, 1, 2, 8'h12, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h13, 0,   0, 1, 3, 8'h13, 1, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0,   0, 0, 3, 8'h13, 1, 0, 0));
        // Frame 2: gapped valid, no consumer release -> WAIT_BANK
        tbl.push_back(mk(1, 0, 8'h00, 0,   1, 0, 3, 8'h13, 1, 0, 0));
        tbl.push_back(mk(0, 1, 8'h20, 0,   1, 1, 0, 8'h20, 1, 0, 0));
        tbl.push_back(mk(0, 0, 8'hEE, 0,   1, 0, 0, 8'h20, 1, 0, 0));
        tbl.push_back(mk(0, 1, 8'h21, 0,   1, 1, 1, 8'h21, 1, 0, 0));
        tbl.push_back(mk(0, 0, 8'hEE, 0,   1, 0, 1, 8'h21, 1, 0, 0));
        tbl.push_back(mk(0, 1, 8'h22, 0,   1, 1, 2, 8'h22, 1, 0, 0));
        tbl.push_back(mk(0, 0, 8'hEE, 0,   1, 0, 2, 8'h22, 1, 0, 0));
        tbl.push_back(mk(0, 1, 8'h23, 0,   0, 1, 3, 8'h23, 1, 1, 0));
        tbl.push_back(mk(0, 1, 8'h99, 0,   0, 0, 3, 8'h23, 1, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1,   0, 0, 3, 8'h23, 0, 0, 0));
        // Frame 3: overrun mid-frame, consumer_done with final accept
        tbl.push_back(mk(1, 0, 8'h00, 0,   1, 0, 3, 8'h23, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h30, 0,   1, 1, 0, 8'h30, 0, 0, 0));
        tbl.push_back(mk(1, 1, 8'h31, 0,   1, 1, 1, 8'h31, 0, 0, 1));
        tbl.push_back(mk(0, 1, 8'h32, 0,   1, 1, 2, 8'h32, 0, 0, 1));
        tbl.push_back(mk(0, 1, 8'h33, 1,   0, 1, 3, 8'h33, 1, 1, 1));
        tbl.push_back(mk(0, 0, 8'h00, 0,   0, 0, 3, 8'h33, 1, 0, 1));
        // Frame 4: WAIT_BANK released by consumer_done together with frame_start
        tbl.push_back(mk(1, 0, 8'h00, 0,   1, 0, 3, 8'h33, 1, 0, 1));
        tbl.push_back(mk(0, 1, 8'h40, 0,   1, 1, 0, 8'h40, 1, 0, 1));
        tbl.push_back(mk(0, 1, 8'h41, 0,   1, 1, 1, 8'h41, 1, 0, 1));
        tbl.push_back(mk(0, 1, 8'h42, 0,   1, 1, 2, 8'h42, 1, 0, 1));
        tbl.push_back(mk(0, 1, 8'h43, 0,   0, 1, 3, 8'h43, 1, 1, 1));
        tbl.push_back(mk(1, 0, 8'h00, 1,   0, 0, 3, 8'h43, 0, 0, 1));
        tbl.push_back(mk(0, 0, 8'h00, 0,   0, 0, 3, 8'h43, 0, 0, 1));
        // Release bank while idle, then Frame 5 goes straight back to IDLE
        tbl.push_back(mk(0, 0, 8'h00, 1,   0, 0, 3, 8'h43, 0, 0, 1));
        tbl.push_back(mk(1, 0, 8'h00, 0,   1, 0, 3, 8'h43, 0, 0, 1));
        tbl.push_back(mk(0, 1, 8'h50, 0,   1, 1, 0, 8'h50, 0, 0, 1));
        tbl.push_back(mk(0, 1, 8'h51, 0,   1, 1, 1, 8'h51, 0, 0, 1));
        tbl.push_back(mk(0, 1, 8'h52, 0,   1, 1, 2, 8'h52, 0, 0, 1));
        tbl.push_back(mk(0, 1, 8'h53, 0,   0, 1, 3, 8'h53, 1, 1, 1));
        // Frame 6 starts, two pixels, then reset hits mid-frame
        tbl.push_back(mk(1, 0, 8'h00, 0,   1, 0, 3, 8'h53, 1, 0, 1));
        tbl.push_back(mk(0, 1, 8'h60, 0,   1, 1, 0, 8'h60, 1, 0, 1));
        tbl.push_back(mk(0, 1, 8'h61, 0,   1, 1, 1, 8'h61, 1, 0, 1));

        repeat (3) @(posedge clk);
        #1;
        check("reset_held", {1'b0, 1'b0, {AW{1'b0}}, 8'h00, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk);
        #1;
        check("reset_released", {1'b0, 1'b0, {AW{1'b0}}, 8'h00, 1'b0, 1'b0, 1'b0});

        for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("vec%0d", i));

        // Asynchronous reset mid-frame: outputs clear without waiting for an edge
        pixel_valid = 1'b1; pixel_in = 8'h62;
        #2;
        n_rst = 1'b0;
        #1;
        check("async_reset", {1'b0, 1'b0, {AW{1'b0}}, 8'h00, 1'b0, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        check("reset_hold_edge", {1'b0, 1'b0, {AW{1'b0}}, 8'h00, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        n_rst = 1'b1;

        step(mk(0, 1, 8'h77, 0,   0, 0, 0, 8'h00, 0, 0, 0), "post_reset_no_write");
        step(mk(1, 0, 8'h00, 0,   1, 0, 0, 8'h00, 0, 0, 0), "post_reset_start");
        step(mk(0, 1, 8'h80, 0,   1, 1, 0, 8'h80, 0, 0, 0), "post_reset_addr0");
        step(mk(0, 1, 8'h81, 0,   1, 1, 1, 8'h81, 0, 0, 0), "post_reset_addr1");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
